// File: rtl/mem_pkg.sv
// Shared types and helpers for the dcache refill path.
//   ADDR_W / BLOCK_DW : default address width and dcache block width
//   MemReq            : one memory request (read/write flags, address, block data)
//   refill_state_t    : refill controller FSM states
//   block_align()     : clears the byte-offset bits of an address
package mem_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BLOCK_DW = 256;

  typedef struct packed {
    logic                read;
    logic                write;
    logic [ADDR_W-1:0]   address;
    logic [BLOCK_DW-1:0] data;
  } MemReq;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4,
    ERR  = 3'd5
  } refill_state_t;

  function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned       offset_bits);
    logic [ADDR_W-1:0] mask;
    mask = ~((ADDR_W'(1) << offset_bits) - ADDR_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_timer.sv
// Response-latency supervisor for the refill controller.
//   clk, rst     : clock, async active-high reset
//   clear_i      : new miss; clears the cycle counter and the retry count
//   retry_i      : a read is being re-issued; restarts the window, counts one retry
//   enable_i     : count this cycle (read issued / waiting for the response)
//   hit_o        : the counter has reached TIMEOUT_CYCLES-1
//   exhausted_o  : MAX_RETRIES re-issues have already been made
module refill_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic retry_i,
  input  logic enable_i,
  output logic hit_o,
  output logic exhausted_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  logic [CNT_W-1:0] count_q, count_d;
  logic [RTY_W-1:0] retry_q, retry_d;

  always_comb begin
    count_d = count_q;
    retry_d = retry_q;
    // Counter saturates rather than wrapping so a stuck window can never alias back to zero.
    if (clear_i || retry_i)                  count_d = '0;
    else if (enable_i && count_q != CNT_SAT) count_d = count_q + CNT_W'(1);
    if (clear_i)                             retry_d = '0;
    else if (retry_i && retry_q != RTY_MAX)  retry_d = retry_q + RTY_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      retry_q <= '0;
    end else begin
      count_q <= count_d;
      retry_q <= retry_d;
    end
  end

  assign hit_o       = (count_q == CNT_LAST);
  assign exhausted_o = (retry_q == RTY_MAX);

endmodule

// File: rtl/dcache_refill_ctrl.sv
// DCache miss initiator: optional victim writeback, block read, refill hold,
// with timeout/retry supervision of the read response.
//   miss_*      : miss request from the dcache (valid/ready; miss_ready_o high only in IDLE)
//   victim_*    : victim block written back first when miss_dirty_i is set
//   refill_*    : captured block offered to the dcache (valid/ready)
//   mem_rd_* / mem_wr_* : single-cycle registered request pulses, block-aligned addresses
//   mem_resp_*  : read response pulse from memory (no backpressure)
//   stray_resp_o: one-cycle pulse for every response that was not accepted
//   error_o     : sticky, retries exhausted; only reset clears it
//   state_o     : current FSM state, for debug/observation
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid is held stable with its payload until that edge.
module dcache_refill_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DCACHE_BLOCK_DW = 256,
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid_i,
  output logic                       miss_ready_o,
  input  logic [ADDRESS_BITS-1:0]    miss_address_i,
  input  logic                       miss_dirty_i,
  input  logic [ADDRESS_BITS-1:0]    victim_address_i,
  input  logic [DCACHE_BLOCK_DW-1:0] victim_data_i,
  output logic                       refill_valid_o,
  input  logic                       refill_ready_i,
  output logic [ADDRESS_BITS-1:0]    refill_address_o,
  output logic [DCACHE_BLOCK_DW-1:0] refill_data_o,
  output logic                       mem_rd_valid_o,
  output logic [ADDRESS_BITS-1:0]    mem_rd_address_o,
  output logic                       mem_wr_valid_o,
  output logic [ADDRESS_BITS-1:0]    mem_wr_address_o,
  output logic [DCACHE_BLOCK_DW-1:0] mem_wr_data_o,
  input  logic                       mem_resp_valid_i,
  input  logic [ADDRESS_BITS-1:0]    mem_resp_address_i,
  input  logic [DCACHE_BLOCK_DW-1:0] mem_resp_data_i,
  output logic                       stray_resp_o,
  output logic                       error_o,
  output refill_state_t              state_o
);

  localparam int unsigned OFFSET_BITS = $clog2(DCACHE_BLOCK_DW / 8);

  refill_state_t              state_q;
  logic                       miss_ready_q, refill_valid_q, rd_valid_q, wr_valid_q;
  logic                       stray_q, error_q;
  logic [ADDRESS_BITS-1:0]    addr_q, wr_addr_q;
  logic [DCACHE_BLOCK_DW-1:0] wr_data_q, refill_data_q;

  logic resp_hit, timeout, retry_fire, timer_hit, retries_done;

  // Only a response in WAIT whose block matches the outstanding miss is accepted.
  assign resp_hit   = (state_q == WAIT) && mem_resp_valid_i &&
                      (block_align(mem_resp_address_i, OFFSET_BITS) == addr_q);
  assign timeout    = (state_q == WAIT) && timer_hit;
  // A response landing on the expiry cycle wins: no re-issue.
  assign retry_fire = timeout && !resp_hit && !retries_done;

  // The RD cycle is the first cycle of each timeout window, so re-issues are
  // spaced exactly TIMEOUT_CYCLES apart.
  refill_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == IDLE),
    .retry_i     (retry_fire),
    .enable_i    ((state_q == RD) || (state_q == WAIT)),
    .hit_o       (timer_hit),
    .exhausted_o (retries_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      miss_ready_q   <= 1'b1;
      refill_valid_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      wr_valid_q     <= 1'b0;
      stray_q        <= 1'b0;
      error_q        <= 1'b0;
      addr_q         <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      refill_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      stray_q    <= mem_resp_valid_i && !resp_hit;
      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            addr_q       <= block_align(miss_address_i, OFFSET_BITS);
            wr_addr_q    <= block_align(victim_address_i, OFFSET_BITS);
            wr_data_q    <= victim_data_i;
            miss_ready_q <= 1'b0;
            if (miss_dirty_i) begin
              state_q    <= WB;
              wr_valid_q <= 1'b1;
            end else begin
              state_q    <= RD;
              rd_valid_q <= 1'b1;
            end
          end
        end
        // Write pulse is already on the bus; read follows in the next cycle so the
        // two requests never overlap.
        WB: begin
          state_q    <= RD;
          rd_valid_q <= 1'b1;
        end
        RD: state_q <= WAIT;
        WAIT: begin
          if (resp_hit) begin
            refill_data_q  <= mem_resp_data_i;
            refill_valid_q <= 1'b1;
            state_q        <= HOLD;
          end else if (timeout) begin
            if (!retries_done) begin
              state_q    <= RD;
              rd_valid_q <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (refill_ready_i) begin
            refill_valid_q <= 1'b0;
            miss_ready_q   <= 1'b1;
            state_q        <= IDLE;
          end
        end
        ERR: ;
        default: begin
          state_q <= ERR;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  assign miss_ready_o     = miss_ready_q;
  assign refill_valid_o   = refill_valid_q;
  assign refill_address_o = addr_q;
  assign refill_data_o    = refill_data_q;
  assign mem_rd_valid_o   = rd_valid_q;
  assign mem_rd_address_o = addr_q;
  assign mem_wr_valid_o   = wr_valid_q;
  assign mem_wr_address_o = wr_addr_q;
  assign mem_wr_data_o    = wr_data_q;
  assign stray_resp_o     = stray_q;
  assign error_o          = error_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;
  import mem_pkg::*;

  localparam int DW = 256;
  localparam logic [DW-1:0] D_AA = {32{8'hAA}};
  localparam logic [DW-1:0] D1   = {8{32'h1111_0001}};
  localparam logic [DW-1:0] D2   = {8{32'h2222_0002}};
  localparam logic [DW-1:0] D3   = {8{32'h3333_0003}};
  localparam logic [DW-1:0] D4   = {8{32'h4444_0004}};
  localparam logic [DW-1:0] D5   = {8{32'h5555_0005}};
  localparam logic [DW-1:0] D6   = {8{32'h6666_0006}};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst_to;

  // shared stimulus
  logic          miss_valid, miss_dirty, refill_ready, resp_valid;
  logic [31:0]   miss_address, victim_address, resp_address;
  logic [DW-1:0] victim_data, resp_data;

  // main DUT outputs
  logic miss_ready, refill_valid, rd_valid, wr_valid, stray, error;
  logic [31:0] refill_address, rd_address, wr_address;
  logic [DW-1:0] refill_data, wr_data;
  refill_state_t state;

  // short-timeout DUT outputs
  logic miss_ready_t, refill_valid_t, rd_valid_t, wr_valid_t, stray_t, error_t;
  logic [31:0] refill_address_t, rd_address_t, wr_address_t;
  logic [DW-1:0] refill_data_t, wr_data_t;
  refill_state_t state_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_address_i(miss_address),
    .miss_dirty_i(miss_dirty), .victim_address_i(victim_address), .victim_data_i(victim_data),
    .refill_valid_o(refill_valid), .refill_ready_i(refill_ready),
    .refill_address_o(refill_address), .refill_data_o(refill_data),
    .mem_rd_valid_o(rd_valid), .mem_rd_address_o(rd_address),
    .mem_wr_valid_o(wr_valid), .mem_wr_address_o(wr_address), .mem_wr_data_o(wr_data),
    .mem_resp_valid_i(resp_valid), .mem_resp_address_i(resp_address), .mem_resp_data_i(resp_data),
    .stray_resp_o(stray), .error_o(error), .state_o(state)
  );

  dcache_refill_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut_to (
    .clk(clk), .rst(rst_to),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready_t), .miss_address_i(miss_address),
    .miss_dirty_i(miss_dirty), .victim_address_i(victim_address), .victim_data_i(victim_data),
    .refill_valid_o(refill_valid_t), .refill_ready_i(refill_ready),
    .refill_address_o(refill_address_t), .refill_data_o(refill_data_t),
    .mem_rd_valid_o(rd_valid_t), .mem_rd_address_o(rd_address_t),
    .mem_wr_valid_o(wr_valid_t), .mem_wr_address_o(wr_address_t), .mem_wr_data_o(wr_data_t),
    .mem_resp_valid_i(resp_valid), .mem_resp_address_i(resp_address), .mem_resp_data_i(resp_data),
    .stray_resp_o(stray_t), .error_o(error_t), .state_o(state_t)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [31:0] addr, input logic dirty);
    miss_address = addr;
    miss_dirty   = dirty;
    miss_valid   = 1'b1;
    tick();
    miss_valid = 1'b0;
    miss_dirty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_to = 1'b1;
    miss_valid = 1'b0; miss_dirty = 1'b0; refill_ready = 1'b0; resp_valid = 1'b0;
    miss_address = '0; victim_address = '0; resp_address = '0; victim_data = '0; resp_data = '0;
    tick(); tick();
    vec_cnt++;
    if ({miss_ready, refill_valid, rd_valid, wr_valid, stray, error} !== 6'b100000) begin
      err_cnt++; $display("FAIL reset_flags: got %b want 100000", {miss_ready, refill_valid, rd_valid, wr_valid, stray, error});
    end
    vec_cnt++;
    if ({refill_address, rd_address, wr_address} !== 96'd0 || refill_data !== '0 || wr_data !== '0 || state !== IDLE) begin
      err_cnt++; $display("FAIL reset_regs: state %0d addr %h/%h/%h not cleared", state, refill_address, rd_address, wr_address);
    end
    vec_cnt++;
    if ({miss_ready_t, refill_valid_t, rd_valid_t, wr_valid_t, stray_t, error_t} !== 6'b100000) begin
      err_cnt++; $display("FAIL reset_flags_to: got %b want 100000", {miss_ready_t, refill_valid_t, rd_valid_t, wr_valid_t, stray_t, error_t});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_miss();
    miss_address = 32'h0000_1234; miss_dirty = 1'b0; miss_valid = 1'b1;
    vec_cnt++;
    if (miss_ready !== 1'b1) begin err_cnt++; $display("FAIL clean_ready: got %b want 1", miss_ready); end
    tick(); miss_valid = 1'b0;                       // cycle 1
    vec_cnt++;
    if ({rd_valid, wr_valid, miss_ready} !== 3'b100 || rd_address !== 32'h0000_1220) begin
      err_cnt++; $display("FAIL clean_rd_pulse: rd/wr/rdy %b addr %h want 100 00001220", {rd_valid, wr_valid, miss_ready}, rd_address);
    end
    for (int c = 2; c < 50; c++) begin
      tick();
      vec_cnt++;
      if ({rd_valid, wr_valid, refill_valid, stray} !== 4'b0000) begin
        err_cnt++; $display("FAIL clean_wait c%0d: got %b want 0000", c, {rd_valid, wr_valid, refill_valid, stray});
      end
    end
    tick();                                          // cycle 50: response
    resp_valid = 1'b1; resp_address = 32'h0000_1220; resp_data = D1;
    tick(); resp_valid = 1'b0;                       // cycle 51
    vec_cnt++;
    if (refill_valid !== 1'b1 || refill_address !== 32'h0000_1220 || refill_data !== D1 || stray !== 1'b0) begin
      err_cnt++; $display("FAIL clean_refill: valid %b addr %h stray %b want 1 00001220 0", refill_valid, refill_address, stray);
    end
    refill_ready = 1'b1;
    tick(); refill_ready = 1'b0;
    vec_cnt++;
    if (refill_valid !== 1'b0 || miss_ready !== 1'b1 || state !== IDLE) begin
      err_cnt++; $display("FAIL clean_done: valid %b ready %b state %0d want 0 1 IDLE", refill_valid, miss_ready, state);
    end
  endtask

  task automatic test_dirty_miss();
    victim_address = 32'h0000_8000; victim_data = D_AA;
    start_miss(32'h0000_4000, 1'b1);                 // cycle 1
    vec_cnt++;
    if ({rd_valid, wr_valid} !== 2'b01 || wr_address !== 32'h0000_8000 || wr_data !== D_AA || state !== WB) begin
      err_cnt++; $display("FAIL dirty_wr_pulse: rd/wr %b addr %h state %0d want 01 00008000 WB", {rd_valid, wr_valid}, wr_address, state);
    end
    tick();                                          // cycle 2
    vec_cnt++;
    if ({rd_valid, wr_valid} !== 2'b10 || rd_address !== 32'h0000_4000) begin
      err_cnt++; $display("FAIL dirty_rd_pulse: rd/wr %b addr %h want 10 00004000", {rd_valid, wr_valid}, rd_address);
    end
    tick();                                          // cycle 3: new miss must be ignored
    miss_valid = 1'b1; miss_address = 32'h0000_7777;
    tick(); miss_valid = 1'b0;                       // cycle 4
    vec_cnt++;
    if ({rd_valid, wr_valid, miss_ready} !== 3'b000 || state !== WAIT || rd_address !== 32'h0000_4000) begin
      err_cnt++; $display("FAIL dirty_ignore_miss: rd/wr/rdy %b state %0d addr %h want 000 WAIT 00004000", {rd_valid, wr_valid, miss_ready}, state, rd_address);
    end
    resp_valid = 1'b1; resp_address = 32'h0000_4010; resp_data = D2;
    tick(); resp_valid = 1'b0;                       // cycle 5
    vec_cnt++;
    if (refill_valid !== 1'b1 || refill_address !== 32'h0000_4000 || refill_data !== D2 || stray !== 1'b0) begin
      err_cnt++; $display("FAIL dirty_refill: valid %b addr %h stray %b want 1 00004000 0", refill_valid, refill_address, stray);
    end
    refill_ready = 1'b1;
    tick(); refill_ready = 1'b0;
  endtask

  task automatic test_stray();
    start_miss(32'h0000_1234, 1'b0);                 // cycle 1
    tick();                                          // cycle 2
    refill_ready = 1'b1;                             // ignored while nothing is offered
    tick();                                          // cycle 3
    resp_valid = 1'b1; resp_address = 32'h0000_9000; resp_data = D3;
    tick(); resp_valid = 1'b0;                       // cycle 4
    vec_cnt++;
    if (stray !== 1'b1 || refill_valid !== 1'b0 || state !== WAIT) begin
      err_cnt++; $display("FAIL stray_pulse: stray %b valid %b state %0d want 1 0 WAIT", stray, refill_valid, state);
    end
    tick();                                          // cycle 5
    vec_cnt++;
    if (stray !== 1'b0 || state !== WAIT || refill_valid !== 1'b0) begin
      err_cnt++; $display("FAIL stray_one_cycle: stray %b state %0d valid %b want 0 WAIT 0", stray, state, refill_valid);
    end
    resp_valid = 1'b1; resp_address = 32'h0000_1220; resp_data = D4;
    tick(); resp_valid = 1'b0;                       // cycle 6
    vec_cnt++;
    if (refill_valid !== 1'b1 || refill_data !== D4) begin
      err_cnt++; $display("FAIL stray_then_hit: valid %b data %h want 1 D4", refill_valid, refill_data[31:0]);
    end
    tick(); refill_ready = 1'b0;                     // cycle 7: handshake completed
    vec_cnt++;
    if (refill_valid !== 1'b0 || state !== IDLE) begin
      err_cnt++; $display("FAIL stray_handshake: valid %b state %0d want 0 IDLE", refill_valid, state);
    end
    resp_valid = 1'b1;                               // duplicate response while idle
    tick(); resp_valid = 1'b0;
    vec_cnt++;
    if (stray !== 1'b1 || state !== IDLE || refill_valid !== 1'b0) begin
      err_cnt++; $display("FAIL stray_idle: stray %b state %0d valid %b want 1 IDLE 0", stray, state, refill_valid);
    end
    tick();
  endtask

  task automatic test_hold_stable();
    start_miss(32'h00AB_CDE4, 1'b0);                 // cycle 1
    tick();                                          // cycle 2
    resp_valid = 1'b1; resp_address = 32'h00AB_CDE0; resp_data = D5;
    tick(); resp_valid = 1'b0;                       // cycle 3: HOLD
    resp_data = D6;
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (refill_valid !== 1'b1 || refill_address !== 32'h00AB_CDE0 || refill_data !== D5 || stray !== (i == 4)) begin
        err_cnt++; $display("FAIL hold_stable i%0d: valid %b addr %h data %h stray %b", i, refill_valid, refill_address, refill_data[31:0], stray);
      end
      resp_valid = (i == 3);
      tick();
    end
    resp_valid = 1'b0;
    refill_ready = 1'b1;
    tick(); refill_ready = 1'b0;
    vec_cnt++;
    if (refill_valid !== 1'b0 || miss_ready !== 1'b1 || state !== IDLE) begin
      err_cnt++; $display("FAIL hold_done: valid %b ready %b state %0d want 0 1 IDLE", refill_valid, miss_ready, state);
    end
  endtask

  task automatic test_timeout_boundary();
    rst_to = 1'b0;
    tick();
    start_miss(32'h0000_2000, 1'b0);                 // cycle 1
    for (int c = 1; c < 16; c++) begin
      vec_cnt++;
      if (rd_valid_t !== (c == 1)) begin
        err_cnt++; $display("FAIL bound_rd c%0d: got %b want %b", c, rd_valid_t, (c == 1));
      end
      tick();
    end
    resp_valid = 1'b1; resp_address = 32'h0000_2000; resp_data = D2;   // cycle 16: expiry cycle
    tick(); resp_valid = 1'b0;                       // cycle 17
    vec_cnt++;
    if (rd_valid_t !== 1'b0 || refill_valid_t !== 1'b1 || refill_data_t !== D2 || error_t !== 1'b0 || state_t !== HOLD) begin
      err_cnt++; $display("FAIL bound_accept: rd %b valid %b err %b state %0d want 0 1 0 HOLD", rd_valid_t, refill_valid_t, error_t, state_t);
    end
    refill_ready = 1'b1;
    tick(); refill_ready = 1'b0;
    vec_cnt++;
    if (state_t !== IDLE || state !== IDLE) begin
      err_cnt++; $display("FAIL bound_done: states %0d/%0d want IDLE", state_t, state);
    end
  endtask

  task automatic test_timeout_retry();
    start_miss(32'h0000_3333, 1'b0);                 // cycle 1
    for (int c = 1; c <= 52; c++) begin
      vec_cnt++;
      if (rd_valid_t !== (c == 1 || c == 17 || c == 33) || error_t !== (c >= 49) || miss_ready_t !== 1'b0) begin
        err_cnt++; $display("FAIL retry c%0d: rd %b err %b rdy %b", c, rd_valid_t, error_t, miss_ready_t);
      end
      vec_cnt++;
      if (rd_valid !== (c == 1) || error !== 1'b0) begin
        err_cnt++; $display("FAIL retry_main c%0d: rd %b err %b", c, rd_valid, error);
      end
      if (rd_valid_t && rd_address_t !== 32'h0000_3320) begin
        err_cnt++; $display("FAIL retry_addr c%0d: got %h want 00003320", c, rd_address_t);
      end
      tick();
    end
    vec_cnt++;
    if (state_t !== ERR || state !== WAIT) begin
      err_cnt++; $display("FAIL retry_states: %0d/%0d want ERR/WAIT", state_t, state);
    end
  endtask

  task automatic test_reset_abort();
    #2;
    rst = 1'b1; rst_to = 1'b1;
    #1;
    vec_cnt++;
    if (state !== IDLE || miss_ready !== 1'b1 || rd_address !== '0 || refill_valid !== 1'b0 || error_t !== 1'b0 || miss_ready_t !== 1'b1) begin
      err_cnt++; $display("FAIL abort_async: state %0d rdy %b addr %h err_t %b rdy_t %b", state, miss_ready, rd_address, error_t, miss_ready_t);
    end
    tick();
    rst = 1'b0; rst_to = 1'b0;
    resp_valid = 1'b1; resp_address = 32'h0000_3320; resp_data = D3;
    tick(); resp_valid = 1'b0;
    vec_cnt++;
    if (stray !== 1'b1 || refill_valid !== 1'b0 || state !== IDLE || stray_t !== 1'b1) begin
      err_cnt++; $display("FAIL abort_late_resp: stray %b valid %b state %0d stray_t %b want 1 0 IDLE 1", stray, refill_valid, state, stray_t);
    end
    tick();
    vec_cnt++;
    if (stray !== 1'b0 || refill_valid !== 1'b0) begin
      err_cnt++; $display("FAIL abort_quiet: stray %b valid %b want 0 0", stray, refill_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stray();
    test_hold_stable();
    test_timeout_boundary();
    test_timeout_retry();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
